// File: rtl/sync_updown_counter_pkg.sv
// Shared types and next-state decision logic for the modulo-N up/down counter.
// Provides the direction enum, a wrap/saturate-aware step selector and a clog2 helper.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic [2:0] {
    STEP_HOLD = 3'd0,
    STEP_INC  = 3'd1,
    STEP_DEC  = 3'd2,
    STEP_ZERO = 3'd3,
    STEP_MAX  = 3'd4
  } step_e;

  typedef struct packed {
    step_e op;
    logic  wrapped;
  } step_t;

  // Picks the counting step from the boundary flags; saturation replaces wrap with hold.
  function automatic step_t next_step(input dir_e dir, input logic at_max,
                                      input logic at_zero, input logic sat);
    step_t r;
    r.op      = STEP_HOLD;
    r.wrapped = 1'b0;
    if (dir == DIR_UP) begin
      if (at_max) begin
        r.op      = sat ? STEP_HOLD : STEP_ZERO;
        r.wrapped = ~sat;
      end else begin
        r.op = STEP_INC;
      end
    end else begin
      if (at_zero) begin
        r.op      = sat ? STEP_HOLD : STEP_MAX;
        r.wrapped = ~sat;
      end else begin
        r.op = STEP_DEC;
      end
    end
    return r;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control/status bundle of the up/down counter: master drives controls, slave is the counter.
interface sync_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/sync_updown_counter_tff_cell.sv
// Single T flip-flop bit cell with asynchronous active-low reset to a per-bit value.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic t_i,
  output logic q_o
);
  logic q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= RST_VAL;
    end else if (t_i) begin
      q_q <= ~q_q;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with clear, load, terminal count and registered wrap pulse.
// Define COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 2 ** WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sync_updown_counter_if.slave  bus
);

`ifdef COUNTER_SAT_EN
  localparam logic SAT_MODE = 1'b1;
`else
  localparam logic SAT_MODE = 1'b0;
`endif

  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             at_max;
  logic             at_zero;
  logic             wrap_q;
  logic             wrap_d;
  step_t            st;

  // One extra bit so MODULUS = 2**WIDTH compares cleanly; the borrow bit flags zero.
  assign count_ext = {1'b0, count_q};
  assign inc_ext   = count_ext + 1'b1;
  assign dec_ext   = count_ext - 1'b1;
  assign at_max    = (inc_ext == MOD_EXT);
  assign at_zero   = dec_ext[WIDTH];

  always_comb begin
    st      = next_step(dir_e'(bus.up_dn), at_max, at_zero, SAT_MODE);
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = RST_BITS;
    end else if (bus.load) begin
      count_d = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : MAX_VAL;
    end else if (bus.en) begin
      wrap_d = st.wrapped;
      case (st.op)
        STEP_INC:  count_d = inc_ext[WIDTH-1:0];
        STEP_DEC:  count_d = dec_ext[WIDTH-1:0];
        STEP_ZERO: count_d = '0;
        STEP_MAX:  count_d = MAX_VAL;
        default:   count_d = count_q;
      endcase
    end
  end

  // Each cell flips only where the next value differs from the current one.
  assign toggle = count_q ^ count_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    tff_cell #(
      .RST_VAL (RST_BITS[gi])
    ) u_tff (
      .clk     (clk),
      .reset_n (reset_n),
      .t_i     (toggle[gi]),
      .q_o     (count_q[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: two counters (MODULUS 10 and 16, WIDTH 4) driven in lockstep against a modular-arithmetic model.
module tb_sync_updown_counter;
  import counter_pkg::*;

  localparam int MOD_A = 10;
  localparam int MOD_B = 16;
  localparam int W     = clog2(MOD_B);
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic en, up_dn, clear, load;
  logic [W-1:0] load_val;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  int mcnt[2];
  bit mwrap[2];
  int mmod[2] = '{MOD_A, MOD_B};

  logic [W-1:0] obs_cnt[2];
  logic         obs_tc[2];
  logic         obs_wrap[2];

  always #5 clk = ~clk;

  sync_updown_counter_if #(.WIDTH(W)) bus_a ();
  sync_updown_counter_if #(.WIDTH(W)) bus_b ();

  assign bus_a.en = en;    assign bus_a.up_dn = up_dn;  assign bus_a.clear = clear;
  assign bus_a.load = load; assign bus_a.load_val = load_val;
  assign bus_b.en = en;    assign bus_b.up_dn = up_dn;  assign bus_b.clear = clear;
  assign bus_b.load = load; assign bus_b.load_val = load_val;

  assign obs_cnt[0] = bus_a.count; assign obs_tc[0] = bus_a.tc; assign obs_wrap[0] = bus_a.wrap;
  assign obs_cnt[1] = bus_b.count; assign obs_tc[1] = bus_b.tc; assign obs_wrap[1] = bus_b.wrap;

  sync_updown_counter #(.WIDTH(W), .MODULUS(MOD_A), .RESET_VAL(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
  sync_updown_counter #(.WIDTH(W), .MODULUS(MOD_B), .RESET_VAL(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

  function automatic bit model_tc(int k);
    if (!en) return 1'b0;
    return up_dn ? (mcnt[k] == mmod[k] - 1) : (mcnt[k] == 0);
  endfunction

  task automatic drive(bit e, bit u, bit c, bit l, int lv);
    en = e; up_dn = u; clear = c; load = l; load_val = W'(lv);
  endtask

  // One clock edge: the model advances on the edge, outputs are observed at the following negedge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) continue;
      if (clear) begin
        mcnt[k] = 0; mwrap[k] = 1'b0;
      end else if (load) begin
        mcnt[k] = (int'(load_val) < mmod[k]) ? int'(load_val) : mmod[k] - 1;
        mwrap[k] = 1'b0;
      end else if (en) begin
        int nxt;
        bit over;
        nxt  = up_dn ? mcnt[k] + 1 : mcnt[k] - 1;
        over = (nxt < 0) || (nxt >= mmod[k]);
        mwrap[k] = over && !SAT;
        if (!over) mcnt[k] = nxt;
        else if (!SAT) mcnt[k] = (nxt + mmod[k]) % mmod[k];
      end else begin
        mwrap[k] = 1'b0;
      end
    end
    @(negedge clk);
    edge_no++;
    $display("edge %0d en=%0b up=%0b clr=%0b ld=%0b lv=%0d | a cnt=%0d wrap=%0b | b cnt=%0d wrap=%0b",
             edge_no, en, up_dn, clear, load, load_val, obs_cnt[0], obs_wrap[0], obs_cnt[1], obs_wrap[1]);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_cnt[k] !== W'(0)) begin errors++; $display("FAIL reset_count dut%0d got %0d want 0", k, obs_cnt[k]); end
      checks++;
      if (obs_wrap[k] !== 1'b0) begin errors++; $display("FAIL reset_wrap dut%0d got %0b want 0", k, obs_wrap[k]); end
    end
    drive(0, 1, 0, 1, 7);
    tick();
    checks++;
    if (obs_cnt[0] !== W'(7)) begin errors++; $display("FAIL reset_preload got %0d want 7", obs_cnt[0]); end
    drive(1, 1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    mcnt = '{0, 0}; mwrap = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_cnt[k] !== W'(0)) begin errors++; $display("FAIL async_reset_count dut%0d got %0d want 0", k, obs_cnt[k]); end
      checks++;
      if (obs_wrap[k] !== 1'b0) begin errors++; $display("FAIL async_reset_wrap dut%0d got %0b want 0", k, obs_wrap[k]); end
    end
    tick();
    checks++;
    if (obs_cnt[0] !== W'(0)) begin errors++; $display("FAIL reset_held got %0d want 0", obs_cnt[0]); end
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_cnt[k] !== W'(1)) begin errors++; $display("FAIL reset_resume dut%0d got %0d want 1", k, obs_cnt[k]); end
    end
  endtask

  task automatic test_up_wrap();
    int exp_a[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    drive(0, 1, 1, 0, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 0, 0, 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_tc[k] !== model_tc(k)) begin errors++; $display("FAIL up_tc dut%0d step %0d got %0b want %0b", k, i, obs_tc[k], model_tc(k)); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_cnt[k] !== W'(mcnt[k])) begin errors++; $display("FAIL up_count dut%0d step %0d got %0d want %0d", k, i, obs_cnt[k], mcnt[k]); end
        checks++;
        if (obs_wrap[k] !== mwrap[k]) begin errors++; $display("FAIL up_wrap dut%0d step %0d got %0b want %0b", k, i, obs_wrap[k], mwrap[k]); end
      end
`ifndef COUNTER_SAT_EN
      checks++;
      if (obs_cnt[0] !== W'(exp_a[i]) || obs_wrap[0] !== (i == 9)) begin
        errors++; $display("FAIL up_table step %0d got cnt=%0d wrap=%0b want cnt=%0d wrap=%0b", i, obs_cnt[0], obs_wrap[0], exp_a[i], (i == 9));
      end
`endif
    end
  endtask

  task automatic test_down_wrap();
    int exp_a[4] = '{1, 0, 9, 8};
    drive(0, 0, 0, 1, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_tc[k] !== model_tc(k)) begin errors++; $display("FAIL down_tc dut%0d step %0d got %0b want %0b", k, i, obs_tc[k], model_tc(k)); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_cnt[k] !== W'(mcnt[k])) begin errors++; $display("FAIL down_count dut%0d step %0d got %0d want %0d", k, i, obs_cnt[k], mcnt[k]); end
        checks++;
        if (obs_wrap[k] !== mwrap[k]) begin errors++; $display("FAIL down_wrap dut%0d step %0d got %0b want %0b", k, i, obs_wrap[k], mwrap[k]); end
      end
`ifndef COUNTER_SAT_EN
      checks++;
      if (obs_cnt[0] !== W'(exp_a[i]) || obs_wrap[0] !== (i == 2)) begin
        errors++; $display("FAIL down_table step %0d got cnt=%0d wrap=%0b want cnt=%0d", i, obs_cnt[0], obs_wrap[0], exp_a[i]);
      end
`endif
    end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 1, 5);
    tick();
    checks++;
    if (obs_cnt[0] !== W'(0) || obs_cnt[1] !== W'(0)) begin errors++; $display("FAIL prio_clear got %0d/%0d want 0/0", obs_cnt[0], obs_cnt[1]); end
    drive(1, 1, 0, 1, 5);
    tick();
    checks++;
    if (obs_cnt[0] !== W'(5) || obs_cnt[1] !== W'(5)) begin errors++; $display("FAIL prio_load got %0d/%0d want 5/5", obs_cnt[0], obs_cnt[1]); end
    drive(1, 1, 0, 1, 12);
    tick();
    checks++;
    if (obs_cnt[0] !== W'(9) || obs_cnt[1] !== W'(12)) begin errors++; $display("FAIL prio_load_clamp got %0d/%0d want 9/12", obs_cnt[0], obs_cnt[1]); end
    checks++;
    if (obs_wrap[0] !== 1'b0) begin errors++; $display("FAIL prio_wrap got %0b want 0", obs_wrap[0]); end
  endtask

  task automatic test_full_range();
    drive(0, 1, 0, 1, 15);
    tick();
    drive(1, 1, 0, 0, 0);
    #1;
    checks++;
    if (obs_tc[1] !== model_tc(1)) begin errors++; $display("FAIL full_tc got %0b want %0b", obs_tc[1], model_tc(1)); end
    tick();
    checks++;
    if (obs_cnt[1] !== W'(mcnt[1]) || obs_wrap[1] !== mwrap[1]) begin
      errors++; $display("FAIL full_wrap got cnt=%0d wrap=%0b want cnt=%0d wrap=%0b", obs_cnt[1], obs_wrap[1], mcnt[1], mwrap[1]);
    end
`ifndef COUNTER_SAT_EN
    checks++;
    if (obs_cnt[1] !== W'(0) || obs_wrap[1] !== 1'b1) begin errors++; $display("FAIL full_wrap_const got cnt=%0d wrap=%0b want 0/1", obs_cnt[1], obs_wrap[1]); end
`endif
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      #1;
      checks++;
      if (obs_tc[0] !== 1'b0 || obs_tc[1] !== 1'b0) begin errors++; $display("FAIL hold_tc step %0d got %0b/%0b want 0/0", i, obs_tc[0], obs_tc[1]); end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_cnt[k] !== W'(mcnt[k]) || obs_wrap[k] !== 1'b0) begin
          errors++; $display("FAIL hold dut%0d step %0d got cnt=%0d wrap=%0b want cnt=%0d wrap=0", k, i, obs_cnt[k], obs_wrap[k], mcnt[k]);
        end
      end
    end
  endtask

`ifdef COUNTER_SAT_EN
  task automatic test_saturate();
    drive(0, 1, 0, 1, 8);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0);
      tick();
      checks++;
      if (obs_cnt[0] !== W'(9) || obs_wrap[0] !== 1'b0) begin errors++; $display("FAIL sat_up step %0d got cnt=%0d wrap=%0b want 9/0", i, obs_cnt[0], obs_wrap[0]); end
    end
    drive(0, 0, 0, 1, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
      checks++;
      if (obs_cnt[0] !== W'(0) || obs_wrap[0] !== 1'b0) begin errors++; $display("FAIL sat_down step %0d got cnt=%0d wrap=%0b want 0/0", i, obs_cnt[0], obs_wrap[0]); end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15));
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_tc[k] !== model_tc(k)) begin errors++; $display("FAIL rand_tc dut%0d iter %0d got %0b want %0b", k, i, obs_tc[k], model_tc(k)); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_cnt[k] !== W'(mcnt[k]) || obs_wrap[k] !== mwrap[k]) begin
          errors++; $display("FAIL rand_state dut%0d iter %0d got cnt=%0d wrap=%0b want cnt=%0d wrap=%0b", k, i, obs_cnt[k], obs_wrap[k], mcnt[k], mwrap[k]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    mcnt = '{0, 0}; mwrap = '{0, 0};
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_full_range();
`ifdef COUNTER_SAT_EN
    test_saturate();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
